// File: rtl/fmul_pkg.sv
// Shared definitions for the floating-point multiplier datapath: significand
// and product widths for binary32/binary64 and the significand multiplier FSM states.
package fmul_pkg;

  localparam int SP_MANT_WIDTH = 24;
  localparam int DP_MANT_WIDTH = 53;
  localparam int SP_PROD_WIDTH = 2 * SP_MANT_WIDTH;
  localparam int DP_PROD_WIDTH = 2 * DP_MANT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fmul_state_t;

endpackage

// File: rtl/mant_mul_step.sv
// One shift-and-add iteration: adds A shifted into place for every set bit
// of the current multiplier slice.
module mant_mul_step #(
  parameter int MANT_WIDTH     = 24,
  parameter int PROD_WIDTH     = 48,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SHIFT_WIDTH    = 5
) (
  input  logic [PROD_WIDTH-1:0]     acc,
  input  logic [MANT_WIDTH-1:0]     a,
  input  logic [BITS_PER_CYCLE-1:0] bits,
  input  logic [SHIFT_WIDTH-1:0]    shift,
  output logic [PROD_WIDTH-1:0]     acc_next
);

  always_comb begin
    acc_next = acc;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (bits[j]) begin
        acc_next = acc_next + (PROD_WIDTH'(a) << (int'(shift) + j));
      end
    end
  end

endmodule

// File: rtl/mant_seq_multiplier.sv
// Iterative significand multiplier feeding rounding_module: retires
// BITS_PER_CYCLE multiplier bits per cycle, then normalises the product once.
module mant_seq_multiplier
  import fmul_pkg::*;
#(
  parameter bit IS_DOUBLE      = 1'b0,
  parameter int MANT_WIDTH     = IS_DOUBLE ? DP_MANT_WIDTH : SP_MANT_WIDTH,
  parameter int PROD_WIDTH     = 2 * MANT_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_WIDTH-1:0] mant_a,
  input  logic [MANT_WIDTH-1:0] mant_b,
  input  logic                  sign_a,
  input  logic                  sign_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PROD_WIDTH-1:0] product,
  output logic                  res_sign,
  output logic                  exp_inc,
  output logic                  zero,
  output logic                  unnorm
);

  localparam int ITER = (MANT_WIDTH + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int BPAD = ITER * BITS_PER_CYCLE;
  localparam int SW   = $clog2(BPAD);
  localparam int CW   = $clog2(ITER + 1);

  fmul_state_t state, state_next;

  logic [MANT_WIDTH-1:0]     a_q;
  logic [BPAD-1:0]           b_q;
  logic [PROD_WIDTH-1:0]     acc, acc_next, norm_prod;
  logic [CW-1:0]             cnt;
  logic [SW-1:0]             k;
  logic [BITS_PER_CYCLE-1:0] slice;
  logic                      accept, zero_op;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the result is held stable in DONE until out_ready, and new
  // operands may be accepted on the same edge the result is consumed.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign zero_op   = (mant_a == '0) || (mant_b == '0);

  assign k     = SW'(int'(cnt) * BITS_PER_CYCLE);
  assign slice = b_q[k +: BITS_PER_CYCLE];

  mant_mul_step #(
    .MANT_WIDTH    (MANT_WIDTH),
    .PROD_WIDTH    (PROD_WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE),
    .SHIFT_WIDTH   (SW)
  ) u_step (
    .acc     (acc),
    .a       (a_q),
    .bits    (slice),
    .shift   (k),
    .acc_next(acc_next)
  );

  // Raw MSB clear means the product is in [1,2); one left shift drops a zero bit.
  assign norm_prod = acc[PROD_WIDTH-1] ? acc : {acc[PROD_WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = zero_op ? DONE : MUL;
      MUL:  if (cnt == CW'(ITER - 1)) state_next = NORM;
      NORM: state_next = DONE;
      DONE: begin
        if (accept)         state_next = zero_op ? DONE : MUL;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
      res_sign <= 1'b0;
      exp_inc  <= 1'b0;
      zero     <= 1'b0;
      unnorm   <= 1'b0;
    end else if (accept) begin
      a_q      <= mant_a;
      b_q      <= BPAD'(mant_b);
      acc      <= '0;
      cnt      <= '0;
      res_sign <= sign_a ^ sign_b;
      product  <= '0;
      exp_inc  <= 1'b0;
      zero     <= zero_op;
      unnorm   <= 1'b0;
    end else if (state == MUL) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
    end else if (state == NORM) begin
      product <= norm_prod;
      exp_inc <= acc[PROD_WIDTH-1];
      unnorm  <= ~norm_prod[PROD_WIDTH-1];
    end
  end

endmodule
